// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control slice.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        CHECK_PARITY_ERROR = 3'd4,
        FIFO_FULL_STATE    = 3'd5,
        LOAD_AFTER_FULL    = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_INVALID    = 2'b11;
    localparam int         TIMEOUT_DEFAULT = 30;

    // Address 3 maps to no port, so every per-port select built from it is zero.
    function automatic logic [2:0] port_onehot(input logic [1:0] a);
        case (a)
            2'd0:    port_onehot = 3'b001;
            2'd1:    port_onehot = 3'b010;
            2'd2:    port_onehot = 3'b100;
            default: port_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/router_if.sv
// Packet-source, FIFO and router_reg signals seen by the router control block.
interface router_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] write_enb;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       busy;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_enb, parity_done, low_pkt_valid,
        input  write_enb, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  busy, vld_out, soft_reset
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb, parity_done, low_pkt_valid,
        output write_enb, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output busy, vld_out, soft_reset
    );
endinterface

// File: rtl/router_sr_timer.sv
// Per-port watchdog: pulses soft_reset when a valid FIFO sits unread for TIMEOUT cycles.
module router_sr_timer #(
    parameter int TIMEOUT = 30
) (
    input  logic clk,
    input  logic resetn,
    input  logic vld,
    input  logic read,
    output logic soft_reset
);
    localparam logic [4:0] TERM = 5'(TIMEOUT - 1);

    logic [4:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (!vld || read) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                cnt        <= '0;
                soft_reset <= 1'b1;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end
endmodule

// File: rtl/router_ctrl.sv
// Router packet-sequencing FSM plus per-port output timeouts.
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header with a valid address
// LOAD_FIRST_DATA    | header accepted, source held for one cycle
// LOAD_DATA          | payload bytes written to the selected FIFO
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | router_reg compares parity
// FIFO_FULL_STATE    | selected FIFO full, source stalled
// LOAD_AFTER_FULL    | writing the byte held across the stall
// WAIT_TILL_EMPTY    | destination still holds an older packet
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic     clk,
    input  logic     resetn,
    router_if.slave  rif
);
    state_t     state, state_nx;
    logic [1:0] addr, addr_nx;
    logic [2:0] sr;
    logic       sel_full, sel_empty, sel_sr, hdr_empty;
    logic       unused_data_bits;

    assign unused_data_bits = ^rif.data_in[7:2];

    assign rif.vld_out    = ~rif.fifo_empty;
    assign rif.soft_reset = sr;

    for (genvar i = 0; i < 3; i++) begin : g_timer
        router_sr_timer #(.TIMEOUT(TIMEOUT)) u_timer (
            .clk        (clk),
            .resetn     (resetn),
            .vld        (~rif.fifo_empty[i]),
            .read       (rif.read_enb[i]),
            .soft_reset (sr[i])
        );
    end

    assign sel_full  = |(rif.fifo_full  & port_onehot(addr));
    assign sel_empty = |(rif.fifo_empty & port_onehot(addr));
    assign sel_sr    = |(sr             & port_onehot(addr));
    assign hdr_empty = |(rif.fifo_empty & port_onehot(rif.data_in[1:0]));

    always_comb begin
        state_nx = state;
        addr_nx  = (state == DECODE_ADDRESS && rif.pkt_valid) ? rif.data_in[1:0] : addr;
        if (sel_sr) begin
            state_nx = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS:
                    if (rif.pkt_valid && rif.data_in[1:0] != ADDR_INVALID)
                        state_nx = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:    state_nx = LOAD_DATA;
                LOAD_DATA:
                    if (sel_full)            state_nx = FIFO_FULL_STATE;
                    else if (!rif.pkt_valid) state_nx = LOAD_PARITY;
                LOAD_PARITY:        state_nx = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_nx = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                FIFO_FULL_STATE:    if (!sel_full) state_nx = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:
                    if (rif.parity_done)        state_nx = DECODE_ADDRESS;
                    else if (rif.low_pkt_valid) state_nx = LOAD_PARITY;
                    else                        state_nx = LOAD_DATA;
                WAIT_TILL_EMPTY:    if (sel_empty) state_nx = LOAD_FIRST_DATA;
                default:            state_nx = DECODE_ADDRESS;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= DECODE_ADDRESS;
            addr            <= 2'd0;
            rif.detect_add  <= 1'b1;
            rif.lfd_state   <= 1'b0;
            rif.ld_state    <= 1'b0;
            rif.laf_state   <= 1'b0;
            rif.full_state  <= 1'b0;
            rif.rst_int_reg <= 1'b0;
            rif.busy        <= 1'b0;
            rif.write_enb   <= 3'b000;
        end else begin
            state           <= state_nx;
            addr            <= addr_nx;
            rif.detect_add  <= (state_nx == DECODE_ADDRESS);
            rif.lfd_state   <= (state_nx == LOAD_FIRST_DATA);
            rif.ld_state    <= (state_nx == LOAD_DATA);
            rif.laf_state   <= (state_nx == LOAD_AFTER_FULL);
            rif.full_state  <= (state_nx == FIFO_FULL_STATE);
            rif.rst_int_reg <= (state_nx == CHECK_PARITY_ERROR);
            rif.busy        <= !(state_nx inside {DECODE_ADDRESS, LOAD_DATA});
            rif.write_enb   <= (state_nx inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL})
                               ? port_onehot(addr_nx) : 3'b000;
        end
    end
endmodule
